// File: rtl/rtc_timeofday.sv
// BCD HH:MM:SS time-of-day counter driven by a 32-bit phase accumulator.
// Define RTC_PPS_SYNC_EN to discipline the second boundary to i_gps_pps.
module rtc_timeofday #(
  parameter logic [31:0] DEFAULT_STEP = 32'd43
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr,
  input  logic [21:0] i_when,
  input  logic [2:0]  i_valid,
  input  logic        i_step_wr,
  input  logic [31:0] i_step,
  input  logic        i_gps_pps,
  output logic [21:0] o_now,
  output logic        o_pps,
  output logic        o_ppd,
  output logic [31:0] o_data
);

  logic [31:0] subsec;
  logic [31:0] step;
  logic        carry;
  logic [32:0] sum;
  logic        ss_ok, mm_ok, hh_ok;
  logic        ld_ss, ld_mm, ld_hh;
  logic        tick, resync, advance, clear;
  logic [21:0] now_inc, now_wr;
  logic        wrap;

  assign sum = {1'b0, subsec} + {1'b0, step};

  assign ss_ok = (i_when[3:0] <= 4'd9) && (i_when[7:4] <= 4'd5);
  assign mm_ok = (i_when[11:8] <= 4'd9) && (i_when[15:12] <= 4'd5);
  assign hh_ok = (i_when[19:16] <= 4'd9) && ({2'b00, i_when[21:16]} <= 8'h23);

  assign ld_ss = i_wr && i_valid[0] && ss_ok;
  assign ld_mm = i_wr && i_valid[1] && mm_ok;
  assign ld_hh = i_wr && i_valid[2] && hh_ok;

`ifdef RTC_PPS_SYNC_EN
  logic [2:0] pps_sync;
  logic       pps_edge;

  always_ff @(posedge i_clk) begin
    if (i_reset) pps_sync <= 3'b000;
    else         pps_sync <= {pps_sync[1:0], i_gps_pps};
  end

  assign pps_edge = pps_sync[1] && !pps_sync[2];
  // A late second (upper half of the accumulator) is emitted on the edge itself.
  assign tick   = carry || (pps_edge && subsec[31]);
  assign resync = pps_edge && !i_wr;
`else
  logic unused_gps_pps;
  assign unused_gps_pps = i_gps_pps;
  assign tick   = carry;
  assign resync = 1'b0;
`endif

  assign advance = tick && !i_wr;
  assign clear   = ld_ss || resync;

  always_comb begin
    now_inc = o_now;
    wrap    = 1'b0;
    if (o_now[3:0] != 4'd9) now_inc[3:0] = o_now[3:0] + 4'd1;
    else begin
      now_inc[3:0] = 4'd0;
      if (o_now[7:4] != 4'd5) now_inc[7:4] = o_now[7:4] + 4'd1;
      else begin
        now_inc[7:4] = 4'd0;
        if (o_now[11:8] != 4'd9) now_inc[11:8] = o_now[11:8] + 4'd1;
        else begin
          now_inc[11:8] = 4'd0;
          if (o_now[15:12] != 4'd5) now_inc[15:12] = o_now[15:12] + 4'd1;
          else begin
            now_inc[15:12] = 4'd0;
            if (o_now[21:16] == 6'h23) begin
              now_inc[21:16] = 6'h00;
              wrap           = 1'b1;
            end else if (o_now[19:16] != 4'd9) begin
              now_inc[19:16] = o_now[19:16] + 4'd1;
            end else begin
              now_inc[19:16] = 4'd0;
              now_inc[21:20] = o_now[21:20] + 2'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    now_wr = o_now;
    if (ld_ss) now_wr[7:0]   = i_when[7:0];
    if (ld_mm) now_wr[15:8]  = i_when[15:8];
    if (ld_hh) now_wr[21:16] = i_when[21:16];
  end

  // Any write cycle swallows a pending tick; illegal fields simply keep their value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      subsec <= 32'd0;
      carry  <= 1'b0;
      step   <= DEFAULT_STEP;
      o_now  <= 22'd0;
      o_pps  <= 1'b0;
      o_ppd  <= 1'b0;
    end else begin
      if (i_step_wr) step <= i_step;
      if (clear) {carry, subsec} <= 33'd0;
      else       {carry, subsec} <= sum;
      if (i_wr)      o_now <= now_wr;
      else if (tick) o_now <= now_inc;
      o_pps <= advance;
      o_ppd <= advance && wrap;
    end
  end

  assign o_data = {10'h000, o_now};

endmodule

// File: tb/tb_rtc_timeofday.sv
// Directed self-checking bench for rtc_timeofday.
module tb_rtc_timeofday;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wr = 1'b0;
  logic [21:0] i_when = '0;
  logic [2:0]  i_valid = '0;
  logic        i_step_wr = 1'b0;
  logic [31:0] i_step = '0;
  logic        i_gps_pps = 1'b0;
  logic [21:0] o_now;
  logic        o_pps;
  logic        o_ppd;
  logic [31:0] o_data;

  int n_checks = 0;
  int n_fail = 0;

  rtc_timeofday dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wr(i_wr), .i_when(i_when),
    .i_valid(i_valid), .i_step_wr(i_step_wr), .i_step(i_step),
    .i_gps_pps(i_gps_pps), .o_now(o_now), .o_pps(o_pps), .o_ppd(o_ppd),
    .o_data(o_data)
  );

  always #5 i_clk = ~i_clk;

  // Called at a falling edge; one rising edge applies the write.
  task automatic write_time(input logic [21:0] when, input logic [2:0] valid);
    i_wr = 1'b1;
    i_when = when;
    i_valid = valid;
    @(negedge i_clk);
    i_wr = 1'b0;
    i_valid = 3'b000;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_wr = 1'b1;
    i_when = 22'h121212;
    i_valid = 3'b111;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (o_now !== 22'h0) begin $display("[TB] FAIL reset_now got %h want 000000", o_now); n_fail++; end
    n_checks++;
    if (o_pps !== 1'b0 || o_ppd !== 1'b0) begin
      $display("[TB] FAIL reset_pulses got pps=%b ppd=%b want 0 0", o_pps, o_ppd); n_fail++;
    end
    n_checks++;
    if (o_data !== 32'h0) begin $display("[TB] FAIL reset_data got %h want 00000000", o_data); n_fail++; end
    n_checks++;
    if (dut.step !== 32'd43) begin $display("[TB] FAIL reset_step got %0d want 43", dut.step); n_fail++; end
    i_reset = 1'b0;
    i_wr = 1'b0;
    i_valid = 3'b000;
  endtask

  task automatic test_count();
    logic [21:0] exp_now;
    logic        exp_pps;
    i_step_wr = 1'b1;
    i_step = 32'h8000_0000;
    write_time(22'h000000, 3'b001);
    i_step_wr = 1'b0;
    n_checks++;
    if (o_now !== 22'h0) begin $display("[TB] FAIL count_start got %h want 000000", o_now); n_fail++; end
    for (int k = 1; k <= 6; k++) begin
      @(negedge i_clk);
      exp_pps = (k >= 3) && (k % 2 == 1);
      exp_now = (k >= 3) ? 22'((k - 1) / 2) : 22'h0;
      n_checks++;
      if (o_pps !== exp_pps || o_now !== exp_now) begin
        $display("[TB] FAIL count k=%0d got now=%h pps=%b want now=%h pps=%b", k, o_now, o_pps, exp_now, exp_pps);
        n_fail++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [21:0] wn [0:5];
    logic [5:0]  wp, wd;
    wn = '{22'h235958, 22'h235958, 22'h235959, 22'h235959, 22'h000000, 22'h000000};
    wp = 6'b010100;
    wd = 6'b010000;
    write_time(22'h235958, 3'b111);
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_now !== wn[k] || o_pps !== wp[k] || o_ppd !== wd[k]) begin
        $display("[TB] FAIL wrap k=%0d got now=%h pps=%b ppd=%b want now=%h pps=%b ppd=%b",
                 k + 1, o_now, o_pps, o_ppd, wn[k], wp[k], wd[k]);
        n_fail++;
      end
    end
  endtask

  task automatic test_field_write();
    write_time(22'h127A30, 3'b111);
    n_checks++;
    if (o_now !== 22'h120030) begin $display("[TB] FAIL bad_minutes got %h want 120030", o_now); n_fail++; end
    write_time(22'h3F4559, 3'b010);
    n_checks++;
    if (o_now !== 22'h124530) begin $display("[TB] FAIL minutes_only got %h want 124530", o_now); n_fail++; end
    write_time(22'h245959, 3'b111);
    n_checks++;
    if (o_now !== 22'h125959) begin $display("[TB] FAIL bad_hours got %h want 125959", o_now); n_fail++; end
    write_time(22'h000060, 3'b001);
    n_checks++;
    if (o_now !== 22'h125959) begin $display("[TB] FAIL bad_seconds got %h want 125959", o_now); n_fail++; end
    n_checks++;
    if (o_data !== 32'h0012_5959) begin $display("[TB] FAIL readback got %h want 00125959", o_data); n_fail++; end
  endtask

  task automatic test_write_vs_tick();
    write_time(22'h101010, 3'b111);
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (dut.carry !== 1'b1) begin $display("[TB] FAIL wvt_carry_setup got %b want 1", dut.carry); n_fail++; end
    write_time(22'h054405, 3'b101);
    n_checks++;
    if (o_pps !== 1'b0 || o_now !== 22'h051005) begin
      $display("[TB] FAIL wvt_sec got now=%h pps=%b want now=051005 pps=0", o_now, o_pps); n_fail++;
    end
    n_checks++;
    if (dut.subsec !== 32'h0) begin $display("[TB] FAIL wvt_subsec_clr got %h want 0", dut.subsec); n_fail++; end
    @(negedge i_clk);
    n_checks++;
    if (o_pps !== 1'b0 || o_now !== 22'h051005) begin
      $display("[TB] FAIL wvt_after got now=%h pps=%b want now=051005 pps=0", o_now, o_pps); n_fail++;
    end
    @(negedge i_clk);
    write_time(22'h002200, 3'b010);
    n_checks++;
    if (o_pps !== 1'b0 || o_now !== 22'h052205) begin
      $display("[TB] FAIL wvt_min got now=%h pps=%b want now=052205 pps=0", o_now, o_pps); n_fail++;
    end
    n_checks++;
    if (dut.subsec !== 32'h8000_0000) begin
      $display("[TB] FAIL wvt_subsec_keep got %h want 80000000", dut.subsec); n_fail++;
    end
    @(negedge i_clk);
    n_checks++;
    if (o_pps !== 1'b0) begin $display("[TB] FAIL wvt_quiet got pps=%b want 0", o_pps); n_fail++; end
    @(negedge i_clk);
    n_checks++;
    if (o_pps !== 1'b1 || o_now !== 22'h052206) begin
      $display("[TB] FAIL wvt_resume got now=%h pps=%b want now=052206 pps=1", o_now, o_pps); n_fail++;
    end
  endtask

  task automatic test_hour_carry();
    write_time(22'h095959, 3'b111);
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (o_pps !== 1'b0 || o_now !== 22'h095959) begin
      $display("[TB] FAIL hour_wait got now=%h pps=%b want now=095959 pps=0", o_now, o_pps); n_fail++;
    end
    @(negedge i_clk);
    n_checks++;
    if (o_now !== 22'h100000 || o_pps !== 1'b1 || o_ppd !== 1'b0) begin
      $display("[TB] FAIL hour_carry got now=%h pps=%b ppd=%b want now=100000 pps=1 ppd=0", o_now, o_pps, o_ppd);
      n_fail++;
    end
  endtask

  task automatic test_freeze();
    i_step_wr = 1'b1;
    i_step = 32'h0;
    write_time(22'h052200, 3'b111);
    i_step_wr = 1'b0;
    n_checks++;
    if (dut.step !== 32'h0) begin $display("[TB] FAIL freeze_step got %h want 0", dut.step); n_fail++; end
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_pps !== 1'b0 || o_now !== 22'h052200) begin
        $display("[TB] FAIL freeze k=%0d got now=%h pps=%b want now=052200 pps=0", k, o_now, o_pps); n_fail++;
      end
    end
    write_time(22'h133700, 3'b110);
    n_checks++;
    if (o_now !== 22'h133700) begin $display("[TB] FAIL freeze_write got %h want 133700", o_now); n_fail++; end
  endtask

  task automatic test_reset_mid();
    i_step_wr = 1'b1;
    i_step = 32'h8000_0000;
    write_time(22'h000000, 3'b001);
    i_step_wr = 1'b0;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (dut.carry !== 1'b1) begin $display("[TB] FAIL rst_carry_setup got %b want 1", dut.carry); n_fail++; end
    i_reset = 1'b1;
    i_wr = 1'b1;
    i_when = 22'h111111;
    i_valid = 3'b111;
    @(negedge i_clk);
    i_reset = 1'b0;
    i_wr = 1'b0;
    i_valid = 3'b000;
    n_checks++;
    if (o_now !== 22'h0 || o_pps !== 1'b0 || o_ppd !== 1'b0 || o_data !== 32'h0) begin
      $display("[TB] FAIL rst_mid_out got now=%h pps=%b ppd=%b data=%h want all 0", o_now, o_pps, o_ppd, o_data);
      n_fail++;
    end
    n_checks++;
    if (dut.step !== 32'd43 || dut.subsec !== 32'h0) begin
      $display("[TB] FAIL rst_mid_state got step=%0d subsec=%h want 43 0", dut.step, dut.subsec); n_fail++;
    end
    @(negedge i_clk);
    n_checks++;
    if (o_pps !== 1'b0) begin $display("[TB] FAIL rst_mid_tick got pps=%b want 0", o_pps); n_fail++; end
  endtask

`ifdef RTC_PPS_SYNC_EN
  task automatic pps_trial(input logic [31:0] preset, input logic exp_tick);
    logic [21:0] exp_now;
    exp_now = exp_tick ? 22'h100000 : 22'h095959;
    i_step_wr = 1'b1;
    i_step = preset;
    write_time(22'h095959, 3'b111);
    i_step = 32'd1;
    @(negedge i_clk);
    i_step_wr = 1'b0;
    i_gps_pps = 1'b1;
    @(negedge i_clk);
    i_gps_pps = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (o_pps !== 1'b0) begin $display("[TB] FAIL pps_early %h k=%0d got pps=%b want 0", preset, k, o_pps); n_fail++; end
      @(negedge i_clk);
    end
    n_checks++;
    if (o_pps !== exp_tick || o_now !== exp_now) begin
      $display("[TB] FAIL pps_edge %h got now=%h pps=%b want now=%h pps=%b", preset, o_now, o_pps, exp_now, exp_tick);
      n_fail++;
    end
    n_checks++;
    if (dut.subsec !== 32'h0) begin $display("[TB] FAIL pps_clear %h got %h want 0", preset, dut.subsec); n_fail++; end
    @(negedge i_clk);
    n_checks++;
    if (o_pps !== 1'b0 || dut.subsec !== 32'h1) begin
      $display("[TB] FAIL pps_after %h got pps=%b subsec=%h want 0 1", preset, o_pps, dut.subsec); n_fail++;
    end
  endtask

  task automatic test_pps_sync();
    pps_trial(32'h9000_0000, 1'b1);
    pps_trial(32'h1000_0000, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_field_write();
    test_write_vs_tick();
    test_hour_carry();
    test_freeze();
    test_reset_mid();
`ifdef RTC_PPS_SYNC_EN
    test_pps_sync();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
